// File: rtl/d16_pkg.sv
// Shared link-register definitions for the 16-bit core datapath.
// Used by the link register and its return-address spill stack.
package d16_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] LR_RESET_VAL = '0;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_CALL = 2'b01,
        OP_RET  = 2'b10,
        OP_BOTH = 2'b11
    } lr_op_e;

    function automatic lr_op_e decode_op(input logic call, input logic ret);
        return lr_op_e'({ret, call});
    endfunction

endpackage

// File: rtl/lr_stack_mem.sv
// Spill storage: one synchronous write port, one asynchronous read port.
// Contents are never reset; validity is tracked by the owner's count.
module lr_stack_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/lr_stack.sv
// Return-address spill stack feeding the link register write port.
// Calls spill lr_cur and load call_addr; returns refill from the top.
module lr_stack
    import d16_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = WORD_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     call_en,
    input  logic [WIDTH-1:0]         call_addr,
    input  logic                     ret_en,
    input  logic [WIDTH-1:0]         lr_cur,
    input  logic                     clear_flags,
    output logic                     lr_wr_en,
    output logic [WIDTH-1:0]         lr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow,
    output logic                     conflict
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]    r_sp;
    logic [CW-1:0]    r_count;
    logic             r_overflow;
    logic             r_underflow;
    logic             r_conflict;

    lr_op_e           w_op;
    logic             w_call;
    logic             w_ret;
    logic             w_both;
    logic             w_empty;
    logic             w_full;
    logic [AW-1:0]    w_rd_addr;
    logic [WIDTH-1:0] w_top;

    assign w_op      = decode_op(call_en, ret_en);
    assign w_call    = (w_op == OP_CALL);
    assign w_ret     = (w_op == OP_RET);
    assign w_both    = (w_op == OP_BOTH);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_rd_addr = r_sp - AW'(1);

    lr_stack_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_call & rst_n),
        .i_waddr (r_sp),
        .i_wdata (lr_cur),
        .i_raddr (w_rd_addr),
        .o_rdata (w_top)
    );

    // Link register write path is purely combinational for zero-bubble refill
    always_comb begin
        lr_wr_en = 1'b0;
        lr_data  = '0;
        unique case (w_op)
            OP_CALL: begin
                lr_wr_en = rst_n;
                lr_data  = call_addr;
            end
            OP_RET: begin
                lr_wr_en = rst_n;
                lr_data  = w_empty ? WIDTH'(LR_RESET_VAL) : w_top;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp        <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            unique case (w_op)
                OP_CALL: begin
                    r_sp <= r_sp + AW'(1);
                    if (!w_full) begin
                        r_count <= r_count + CW'(1);
                    end
                end
                OP_RET: begin
                    if (!w_empty) begin
                        r_sp    <= r_sp - AW'(1);
                        r_count <= r_count - CW'(1);
                    end
                end
                default: ;
            endcase
            r_overflow  <= (r_overflow & ~clear_flags) | (w_call & w_full);
            r_underflow <= (r_underflow & ~clear_flags) | (w_ret & w_empty);
            r_conflict  <= (r_conflict & ~clear_flags) | w_both;
        end
    end

    assign count     = r_count;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign conflict  = r_conflict;

endmodule

// File: tb/tb_lr_stack.sv
// Self-checking bench for lr_stack against a queue-based stack model.
// Directed scenarios with literal checks, then randomized traffic.
module tb_lr_stack;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst_n;
    logic             call_en;
    logic [WIDTH-1:0] call_addr;
    logic             ret_en;
    logic [WIDTH-1:0] lr_cur;
    logic             clear_flags;
    logic             lr_wr_en;
    logic [WIDTH-1:0] lr_data;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;
    logic             conflict;

    lr_stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .call_en     (call_en),
        .call_addr   (call_addr),
        .ret_en      (ret_en),
        .lr_cur      (lr_cur),
        .clear_flags (clear_flags),
        .lr_wr_en    (lr_wr_en),
        .lr_data     (lr_data),
        .count       (count),
        .empty       (empty),
        .full        (full),
        .overflow    (overflow),
        .underflow   (underflow),
        .conflict    (conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Model: a bounded LIFO of spilled values; oldest drops off when full
    logic [WIDTH-1:0] q[$];
    logic m_ov, m_un, m_cf;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 1'b0;
        m_un = 1'b0;
        m_cf = 1'b0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        if (rst_n) begin
            logic s_ov, s_un, s_cf;
            s_ov = 1'b0;
            s_un = 1'b0;
            s_cf = 1'b0;
            if (call_en && ret_en) begin
                s_cf = 1'b1;
            end else if (call_en) begin
                if (q.size() == DEPTH) begin
                    void'(q.pop_front());
                    s_ov = 1'b1;
                end
                q.push_back(lr_cur);
            end else if (ret_en) begin
                if (q.size() > 0) void'(q.pop_back());
                else s_un = 1'b1;
            end
            m_ov = (m_ov & ~clear_flags) | s_ov;
            m_un = (m_un & ~clear_flags) | s_un;
            m_cf = (m_cf & ~clear_flags) | s_cf;
        end
    end

    always @(negedge clk) begin
        logic             e_wr;
        logic [WIDTH-1:0] e_data;
        logic             chk_data;
        e_wr     = 1'b0;
        e_data   = '0;
        chk_data = 1'b1;
        if (!rst_n) begin
            chk_data = 1'b0;
        end else if (call_en && !ret_en) begin
            e_wr   = 1'b1;
            e_data = call_addr;
        end else if (ret_en && !call_en) begin
            e_wr   = 1'b1;
            e_data = (q.size() > 0) ? q[$] : '0;
        end else if (call_en && ret_en) begin
            chk_data = 1'b0;
        end
        chk("lr_wr_en", 32'(lr_wr_en), 32'(e_wr));
        if (chk_data) chk("lr_data", 32'(lr_data), 32'(e_data));
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("underflow", 32'(underflow), 32'(m_un));
        chk("conflict", 32'(conflict), 32'(m_cf));
    end

    // Apply inputs just after a rising edge; return just after the next falling edge
    task automatic op(input logic c, input logic r, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] cur, input logic clr);
        @(posedge clk);
        #1;
        call_en     = c;
        ret_en      = r;
        call_addr   = a;
        lr_cur      = cur;
        clear_flags = clr;
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        op(1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        rst_n       = 1'b0;
        call_en     = 1'b0;
        ret_en      = 1'b0;
        call_addr   = '0;
        lr_cur      = '0;
        clear_flags = 1'b0;
        #22;
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        chk("reset_wr", 32'(lr_wr_en), 32'd0);
        rst_n = 1'b1;

        // Basic nesting
        op(1'b1, 1'b0, 16'h1110, 16'h0000, 1'b0);
        chk("call1_data", 32'(lr_data), 32'h1110);
        op(1'b1, 1'b0, 16'h2220, 16'h1110, 1'b0);
        chk("call2_data", 32'(lr_data), 32'h2220);
        op(1'b1, 1'b0, 16'h3330, 16'h2220, 1'b0);
        chk("call3_data", 32'(lr_data), 32'h3330);
        op(1'b0, 1'b1, '0, '0, 1'b0);
        chk("count_3", 32'(count), 32'd3);
        chk("ret1_data", 32'(lr_data), 32'h2220);
        op(1'b0, 1'b1, '0, '0, 1'b0);
        chk("ret2_data", 32'(lr_data), 32'h1110);
        op(1'b0, 1'b1, '0, '0, 1'b0);
        chk("ret3_data", 32'(lr_data), 32'h0000);
        idle();
        chk("count_0", 32'(count), 32'd0);
        chk("empty_1", 32'(empty), 32'd1);

        // Overflow / wrap
        for (int i = 1; i <= 10; i++) begin
            op(1'b1, 1'b0, 16'(i + 16'h100), 16'(i), 1'b0);
            if (i == 9) begin
                chk("full_after8", 32'(full), 32'd1);
                chk("no_ovf_yet", 32'(overflow), 32'd0);
            end
            if (i == 10) chk("ovf_after9", 32'(overflow), 32'd1);
        end
        for (int j = 0; j < 9; j++) begin
            op(1'b0, 1'b1, '0, '0, 1'b0);
            if (j < 8) chk("wrap_ret", 32'(lr_data), 32'(10 - j));
            else begin
                chk("uf_ret_wr", 32'(lr_wr_en), 32'd1);
                chk("uf_ret_data", 32'(lr_data), 32'd0);
            end
        end
        idle();
        chk("uf_flag", 32'(underflow), 32'd1);
        op(1'b0, 1'b0, '0, '0, 1'b1);
        idle();
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_uf", 32'(underflow), 32'd0);

        // Conflict
        op(1'b1, 1'b0, 16'hA000, 16'h0A0A, 1'b0);
        op(1'b1, 1'b0, 16'hB000, 16'h0B0B, 1'b0);
        op(1'b1, 1'b1, 16'hC000, 16'h0C0C, 1'b0);
        chk("conf_wr", 32'(lr_wr_en), 32'd0);
        idle();
        chk("conf_count", 32'(count), 32'd2);
        chk("conf_flag", 32'(conflict), 32'd1);
        op(1'b0, 1'b0, '0, '0, 1'b1);
        idle();
        chk("conf_clr", 32'(conflict), 32'd0);

        // Drain then return on empty
        op(1'b0, 1'b1, '0, '0, 1'b0);
        chk("drain1", 32'(lr_data), 32'h0B0B);
        op(1'b0, 1'b1, '0, '0, 1'b0);
        chk("drain2", 32'(lr_data), 32'h0A0A);
        op(1'b0, 1'b1, '0, '0, 1'b0);
        chk("empty_ret_wr", 32'(lr_wr_en), 32'd1);
        chk("empty_ret_data", 32'(lr_data), 32'd0);
        idle();
        chk("empty_ret_uf", 32'(underflow), 32'd1);
        chk("empty_ret_cnt", 32'(count), 32'd0);

        // Mid-cycle asynchronous reset with 5 entries
        for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 16'h4000, 16'(16'h50 + i), 1'b0);
        op(1'b1, 1'b1, '0, '0, 1'b0);
        @(posedge clk);
        #1;
        call_en   = 1'b1;
        ret_en    = 1'b0;
        call_addr = 16'h7777;
        lr_cur    = 16'h5A5A;
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_conf", 32'(conflict), 32'd0);
        chk("arst_uf", 32'(underflow), 32'd0);
        chk("arst_wr", 32'(lr_wr_en), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        op(1'b0, 1'b1, '0, '0, 1'b0);
        chk("post_rst_pop", 32'(lr_data), 32'h5A5A);
        idle();
        chk("post_rst_cnt", 32'(count), 32'd0);

        // Randomized traffic biased toward deep nesting
        for (int n = 0; n < 600; n++) begin
            int unsigned r;
            logic c, rt;
            r  = $urandom_range(0, 99);
            c  = (n % 200 < 100) ? (r < 60) : (r < 30);
            rt = (n % 200 < 100) ? (r >= 55 && r < 85) : (r >= 25 && r < 85);
            op(c, rt, 16'($urandom), 16'($urandom), ($urandom_range(0, 19) == 0));
        end
        idle();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lr_stack.md
# lr_stack

Return-address spill stack sitting directly upstream of the link register. It drives the link register's write port on every call and return. On a call it spills the current link value into a small hardware stack and loads the new return address. On a return it refills the link register from the stack top. Nested calls are thereby restored without software save/restore, up to DEPTH levels deep.

## Interface
- DEPTH, 8: stack entries; power of two, ≥2.
- WIDTH, 16: data word width; equals the link register width.

- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- call_en  in  1  call request this cycle (push).
- call_addr  in  WIDTH  return address to load into the link register on call.
- ret_en  in  1  return request this cycle (pop).
- lr_cur  in  WIDTH  current link register contents (link register output).
- clear_flags  in  1  synchronous clear of the sticky flags.
- lr_wr_en  out  1  link register write enable; combinational.
- lr_data  out  WIDTH  link register write data; combinational.
- count  out  $clog2(DEPTH)+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky: a call occurred while full.
- underflow  out  1  sticky: a return occurred while empty.
- conflict  out  1  sticky: call_en and ret_en were both asserted.

## Operation
- Storage is DEPTH×WIDTH and treated as circular. Write pointer sp is $clog2(DEPTH) bits and wraps modulo DEPTH. Occupancy is tracked separately in count.
- Call (call_en=1, ret_en=0):
  - lr_wr_en=1, lr_data=call_addr.
  - On the edge: mem[sp]←lr_cur, sp←sp+1.
  - count←count+1, saturating at DEPTH.
- Call while full: the oldest entry is silently overwritten through pointer wrap. count stays at DEPTH and overflow←1.
- Return (ret_en=1, call_en=0), not empty:
  - lr_wr_en=1, lr_data=mem[sp−1].
  - On the edge: sp←sp−1, count←count−1.
- Return while empty: lr_wr_en=1, lr_data=0. sp and count are unchanged; underflow←1.
- Both call_en and ret_en asserted: no operation. lr_wr_en=0, stack state is unchanged, and conflict←1.
- Neither asserted: lr_wr_en=0 and lr_data=0.
- clear_flags=1 clears all three sticky flags on the edge.
  - If a flag-setting event occurs in the same cycle, the set wins.
- Memory contents are not reset. Valid data is gated solely by count.

## Timing
- The request-to-link-register path is combinational. The link register captures lr_data on the same edge on which the stack updates, giving zero bubble cycles.
- Back-to-back calls or returns are supported every cycle. lr_cur is guaranteed current because the link register updates on the same edge as the stack.
- A call immediately after a return pushes the refilled value, which is correct nesting behaviour.
- Reset values: sp=0, count=0, empty=1, full=0, overflow=0, underflow=0, conflict=0.
- lr_wr_en is forced to 0 while rst_n=0.
- Reset asserted mid-sequence clears all state immediately (asynchronously). The first edge after deassertion behaves as for an empty stack.
- count, empty, full and the flags are registered; they reflect the update one cycle after the request edge.
- Wrap-around: after DEPTH+k calls, the next DEPTH returns yield the most recent DEPTH spilled values in LIFO order. Any further returns are underflow.

## Structure
- Shared package d16_pkg holds WORD_W=16 and LR_RESET_VAL=0. These are used here and by the link register.
- One sub-module, lr_stack_mem: DEPTH×WIDTH register file with one synchronous write port and one asynchronous read port (read address sp−1). It has no reset.
- The top level holds sp, count, the flags and the output mux.

## Test plan
- Reset, then 3 calls with lr_cur = 0x0000, 0x1110, 0x2220 and call_addr = 0x1110, 0x2220, 0x3330 → lr_data follows call_addr each cycle; count=3.
- Then 3 returns → lr_data=0x2220, 0x1110, 0x0000 in order; count=0 and empty=1.
- DEPTH=8: 10 calls with lr_cur values 1..10, then 9 returns:
  - full=1 after the 8th call; overflow=1 after the 9th.
  - Returns yield 10..3; the 9th return gives lr_data=0 and sets underflow=1.
- call_en and ret_en both high with count=2 → lr_wr_en=0; count stays 2; conflict=1. Then clear_flags → conflict=0.
- Return on an empty stack → lr_wr_en=1, lr_data=0x0000, underflow=1; sp and count unchanged.
- Assert rst_n low for half a cycle between edges with count=5 → count=0 and all flags 0 immediately, lr_wr_en=0. The next call pushes to entry 0.
